// File: rtl/adder_pkg.sv
// Shared types for the serial adder: FSM state encoding and parameter sanity check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal shapes: at least two bits wide, whole number of digits per operand.
    function automatic bit width_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Purpose: combinational DIGIT-bit ripple adder from full-adder cells (two half adders + OR).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             ctop_o
);

    logic carry;
    logic hs;
    logic hc;
    logic fc;

    always_comb begin
        sum_o  = '0;
        ctop_o = cin_i;
        carry  = cin_i;
        hs     = 1'b0;
        hc     = 1'b0;
        fc     = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            // Left holding the carry into bit DIGIT-1 after the final pass.
            ctop_o   = carry;
            hs       = a_i[i] ^ b_i[i];
            hc       = a_i[i] & b_i[i];
            sum_o[i] = hs ^ carry;
            fc       = hs & carry;
            carry    = hc | fc;
        end
        cout_o = carry;
    end

endmodule

// File: rtl/serial_adder.sv
// Purpose: WIDTH-bit a+b+cin computed DIGIT bits per clock, with carry-out and signed overflow.
// Latency: start accepted in cycle t -> done_o pulses in cycle t+WIDTH/DIGIT+1.
// Backpressure: ready_o low while running; start_i is dropped (not queued) when ready_o=0.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_ctop;
    logic [WIDTH-1:0] res_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout),
        .ctop_o (dig_ctop)
    );

    // New digit enters at the MSB end; after NDIG steps the LSB digit has reached bit 0.
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = dig_cout;
                    ovf_d   = dig_ctop ^ dig_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o = (state_q != RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across four shapes: 8x1, 8x4, 4x1 and 4x2 bits per digit.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic       st81, c81, r81, d81, co81, ov81;
    logic [7:0] a81, b81, s81;
    logic       st84, c84, r84, d84, co84, ov84;
    logic [7:0] a84, b84, s84;
    logic       st41, c41, r41, d41, co41, ov41;
    logic [3:0] a41, b41, s41;
    logic       st42, c42, r42, d42, co42, ov42;
    logic [3:0] a42, b42, s42;

    exp_t q81[$];
    exp_t q84[$];
    exp_t q41[$];
    exp_t q42[$];
    int   done_cnt[4];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .rst_n(rst_n), .start_i(st81), .a_i(a81), .b_i(b81), .cin_i(c81),
        .ready_o(r81), .done_o(d81), .sum_o(s81), .cout_o(co81), .ovf_o(ov81));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start_i(st84), .a_i(a84), .b_i(b84), .cin_i(c84),
        .ready_o(r84), .done_o(d84), .sum_o(s84), .cout_o(co84), .ovf_o(ov84));
    serial_adder #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .rst_n(rst_n), .start_i(st41), .a_i(a41), .b_i(b41), .cin_i(c41),
        .ready_o(r41), .done_o(d41), .sum_o(s41), .cout_o(co41), .ovf_o(ov41));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .rst_n(rst_n), .start_i(st42), .a_i(a42), .b_i(b42), .cin_i(c42),
        .ready_o(r42), .done_o(d42), .sum_o(s42), .cout_o(co42), .ovf_o(ov42));

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Packed view {ready, done, cout, ovf, sum[7:0]} of one instance.
    function automatic logic [11:0] outs(input int id);
        case (id)
            0:       return {r81, d81, co81, ov81, s81};
            1:       return {r84, d84, co84, ov84, s84};
            2:       return {r41, d41, co41, ov41, 4'h0, s41};
            default: return {r42, d42, co42, ov42, 4'h0, s42};
        endcase
    endfunction

    function automatic int pend(input int id);
        case (id)
            0:       return q81.size();
            1:       return q84.size();
            2:       return q41.size();
            default: return q42.size();
        endcase
    endfunction

    task automatic push_exp(input int id, input exp_t e);
        case (id)
            0:       q81.push_back(e);
            1:       q84.push_back(e);
            2:       q41.push_back(e);
            default: q42.push_back(e);
        endcase
    endtask

    task automatic drive(input int id, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        case (id)
            0:       begin st81 = s; a81 = a;      b81 = b;      c81 = c; end
            1:       begin st84 = s; a84 = a;      b84 = b;      c84 = c; end
            2:       begin st41 = s; a41 = a[3:0]; b41 = b[3:0]; c41 = c; end
            default: begin st42 = s; a42 = a[3:0]; b42 = b[3:0]; c42 = c; end
        endcase
    endtask

    task automatic mon(input int id, input logic [11:0] o);
        exp_t e;
        bit   have;
        have = 1'b0;
        done_cnt[id]++;
        case (id)
            0:       if (q81.size() != 0) begin e = q81.pop_front(); have = 1'b1; end
            1:       if (q84.size() != 0) begin e = q84.pop_front(); have = 1'b1; end
            2:       if (q41.size() != 0) begin e = q41.pop_front(); have = 1'b1; end
            default: if (q42.size() != 0) begin e = q42.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst%0d: got done_o=1, required no pending result", id);
        end else begin
            chk($sformatf("result_inst%0d", id), {2'b00, o[9], o[8], o[7:0]},
                {2'b00, e.cout, e.ovf, e.sum});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (d81) mon(0, outs(0));
            if (d84) mon(1, outs(1));
            if (d41) mon(2, outs(2));
            if (d42) mon(3, outs(3));
        end
    end

    // Waits (bounded) for ready, presents start for one cycle, records the expected result.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit do_push, input logic [7:0] es, input logic eco,
                         input logic eov);
        int n;
        n = 0;
        while (outs(id)[11] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (outs(id)[11] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst%0d: got ready_o=0 after %0d cycles, required 1", id, n);
        end
        drive(id, 1'b1, a, b, c);
        if (do_push) push_exp(id, {es, eco, eov});
        @(negedge clk);
        drive(id, 1'b0, a, b, c);
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (pend(id) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_inst%0d", id), 12'(pend(id)), 12'd0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [4:0] tot;
        logic [3:0] av, bv;
        logic       cv, eov;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("reset_inst%0d", i), outs(i), 12'h800);
        rst_n = 1'b1;
        @(negedge clk);

        // 8x1: nine-cycle latency, ready low throughout RUN.
        issue(0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t1_busy_cycle%0d", i), {10'b0, r81, d81}, 12'b00);
            @(negedge clk);
        end
        chk("t1_done_at_t9", {11'b0, d81}, 12'd1);
        drain(0);

        issue(0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        issue(0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        issue(0, 8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        drain(0);

        // 8x4: three-cycle latency, restart from the DONE cycle.
        issue(1, 8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("t3_busy1", {10'b0, r84, d84}, 12'b00);
        @(negedge clk);
        chk("t3_busy2", {10'b0, r84, d84}, 12'b00);
        @(negedge clk);
        chk("t3_done_at_t3", {10'b0, r84, d84}, 12'b11);
        drive(1, 1'b1, 8'h01, 8'h02, 1'b0);
        push_exp(1, {8'h03, 1'b0, 1'b0});
        @(negedge clk);
        drive(1, 1'b0, 8'h01, 8'h02, 1'b0);
        chk("t3_restart_busy", {10'b0, r84, d84}, 12'b00);
        @(negedge clk);
        chk("t3_hold_prev", {3'b0, co84, s84}, {3'b0, 1'b1, 8'h00});
        @(negedge clk);
        chk("t3_second_done", {11'b0, d84}, 12'd1);
        drain(1);

        // Start pulsed during RUN must be dropped.
        base = done_cnt[0];
        issue(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF, 8'hFF, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_single_done", 12'(done_cnt[0] - base), 12'd1);

        // Reset in cycle t+4 of an op, with start held high during reset.
        issue(0, 8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        #1;
        chk("t5_async_reset", outs(0), 12'h800);
        repeat (3) @(negedge clk);
        chk("t5_start_in_reset", outs(0), 12'h800);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        base = done_cnt[0];
        repeat (12) @(negedge clk);
        chk("t5_idle_after_reset", outs(0), 12'h800);
        chk("t5_no_done", 12'(done_cnt[0] - base), 12'd0);
        issue(0, 8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0);
        drain(0);

        // Exhaustive 4-bit sweep on both digit widths.
        for (int id = 2; id <= 3; id++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        av  = 4'(ai);
                        bv  = 4'(bi);
                        cv  = 1'(ci);
                        tot = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
                        eov = (av[3] == bv[3]) && (tot[3] != av[3]);
                        issue(id, {4'h0, av}, {4'h0, bv}, cv, 1'b1, {4'h0, tot[3:0]}, tot[4], eov);
                    end
                end
            end
            drain(id);
        end

        for (int i = 0; i < 4; i++) chk($sformatf("final_empty_inst%0d", i), 12'(pend(i)), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
